// File: rtl/clip_player_pkg.sv
// clip_player_pkg
//   Shared definitions for the clip player: playback FSM encoding, the
//   default clip bounds of the stock sound ROM, and the codec sample width.
package clip_player_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Audio codec sample width (left-justified samples).
    localparam int CODEC_W = 32;

    // Stock ROM layout: four clips, 18-bit addresses.
    localparam int DEF_NUM_CLIPS = 4;
    localparam int DEF_ADDR_W    = 18;

    localparam logic [DEF_ADDR_W-1:0] WIN_START    = 18'd0;
    localparam logic [DEF_ADDR_W-1:0] WIN_END      = 18'd16395;
    localparam logic [DEF_ADDR_W-1:0] MOO_START    = 18'd16396;
    localparam logic [DEF_ADDR_W-1:0] MOO_END      = 18'd66982;
    localparam logic [DEF_ADDR_W-1:0] DETECT_START = 18'd66983;
    localparam logic [DEF_ADDR_W-1:0] DETECT_END   = 18'd83254;
    localparam logic [DEF_ADDR_W-1:0] CHEER_START  = 18'd83255;
    localparam logic [DEF_ADDR_W-1:0] CHEER_END    = 18'd137138;

    // Clip i lives in bits [i*ADDR_W +: ADDR_W]; clip 0 is the LSB slice.
    localparam logic [DEF_NUM_CLIPS*DEF_ADDR_W-1:0] DEF_CLIP_START =
        {CHEER_START, DETECT_START, MOO_START, WIN_START};
    localparam logic [DEF_NUM_CLIPS*DEF_ADDR_W-1:0] DEF_CLIP_END =
        {CHEER_END, DETECT_END, MOO_END, WIN_END};

endpackage

// File: rtl/clip_player_tick.sv
// sample_tick
//   Sample-rate divider. Counts 0..DIV-1 while enabled and flags the last
//   count so the caller can act on the same edge the counter wraps.
//   Ports:
//     clk_i  - clock
//     rst_i  - synchronous active-high reset (counter to 0)
//     clr_i  - restart the period (counter to 0), wins over en_i
//     en_i   - advance the counter this cycle; when low the count holds
//     tick_o - high in the cycle whose edge ends a period
module sample_tick #(
    parameter int DIV = 1200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clip_player.sv
// clip_player
//   Plays sound clips out of an external synchronous sample ROM into an
//   audio codec FIFO at one sample every DIV clocks. Playback runs in real
//   time: a sample the FIFO cannot take is dropped, never delayed.
//   Ports:
//     CLOCK_50                - system clock
//     reset                   - synchronous active-high reset
//     trigger/clip_sel/loop_mode - start request, clip index, repeat flag
//     stop                    - abort playback (wins over trigger)
//     atten                   - output attenuation, arithmetic shift 0..3
//     rom_addr/rom_q          - ROM address out, data back one cycle later
//     audio_out_allowed       - codec FIFO has room
//     write_audio_out         - one-cycle sample write strobe
//     left/right_channel_audio_out - left-justified 32-bit samples
//     busy/done/dropped/cur_clip   - status; done and dropped are pulses
module clip_player
    import clip_player_pkg::*;
#(
    parameter int NUM_CLIPS = DEF_NUM_CLIPS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SAMPLE_W  = 6,
    parameter int DIV       = 1200,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START = DEF_CLIP_START,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END   = DEF_CLIP_END,
    parameter int STEREO    = 0
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         trigger,
    input  logic [$clog2(NUM_CLIPS)-1:0] clip_sel,
    input  logic                         loop_mode,
    input  logic                         stop,
    input  logic [1:0]                   atten,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_q,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [CODEC_W-1:0]           left_channel_audio_out,
    output logic [CODEC_W-1:0]           right_channel_audio_out,
    output logic                         busy,
    output logic                         done,
    output logic                         dropped,
    output logic [$clog2(NUM_CLIPS)-1:0] cur_clip
);

    localparam int SEL_W = $clog2(NUM_CLIPS);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SEL_W-1:0]   cur_clip_q, cur_clip_d;
    logic               loop_q, loop_d;
    logic [CODEC_W-1:0] left_q, left_d;
    logic [CODEC_W-1:0] right_q, right_d;
    logic               wr_q, wr_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;

    logic               trig_ok, accept, tick_en, tick, at_end;
    logic [ADDR_W-1:0]  sel_start, cur_start, cur_end;
    logic signed [CODEC_W-1:0] samp_full;

    // An out-of-range clip index is not a request at all; stop beats trigger.
    assign trig_ok = trigger && (int'(clip_sel) < NUM_CLIPS);
    assign accept  = trig_ok && !stop;

    assign sel_start = CLIP_START[int'(clip_sel) * ADDR_W +: ADDR_W];
    assign cur_start = CLIP_START[int'(cur_clip_q) * ADDR_W +: ADDR_W];
    assign cur_end   = CLIP_END[int'(cur_clip_q) * ADDR_W +: ADDR_W];
    assign at_end    = (addr_q == cur_end);

    // Signed so the attenuation shift keeps the sign.
    assign samp_full = {rom_q, {(CODEC_W - SAMPLE_W){1'b0}}};

    // The period counter only runs while playing; a stop freezes it and an
    // accepted trigger restarts it, so neither produces a strobe.
    assign tick_en = (state_q == ST_PLAY) && !stop;

    sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .clr_i  (accept),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (stop)                          state_d = ST_IDLE;
                else if (accept)                   state_d = ST_PLAY;
                else if (tick && at_end && !loop_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_PLAY);
    end

    // ---------------- datapath ----------------
    always_comb begin
        addr_d     = addr_q;
        cur_clip_d = cur_clip_q;
        loop_d     = loop_q;
        left_d     = left_q;
        right_d    = right_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        if (accept) begin
            cur_clip_d = clip_sel;
            loop_d     = loop_mode;
            addr_d     = sel_start;
        end else if (tick) begin
            left_d  = samp_full >>> atten;
            right_d = (STEREO != 0) ? left_d : '0;
            wr_d    = audio_out_allowed;
            drop_d  = !audio_out_allowed;
            // Address moves on even when the sample is dropped.
            if (!at_end) begin
                addr_d = addr_q + 1'b1;
            end else if (loop_q) begin
                addr_d = cur_start;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            addr_q     <= '0;
            cur_clip_q <= '0;
            loop_q     <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cur_clip_q <= cur_clip_d;
            loop_q     <= loop_d;
            left_q     <= left_d;
            right_q    <= right_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign rom_addr                = addr_q;
    assign cur_clip                = cur_clip_q;
    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = right_q;
    assign write_audio_out         = wr_q;
    assign done                    = done_q;
    assign dropped                 = drop_q;

endmodule
